// File: rtl/led_counter_sequencer.sv
// Run/pause/single-step sequencer for the prescaled LED counter.
// Debounces the run and step buttons and owns the prescaler and the up/down count.
module led_counter_sequencer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned TICK_DIV  = 25_000_000,
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run_n,
    input  logic             i_step_n,
    input  logic             i_dir,
    input  logic [1:0]       i_speed,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tick,
    output logic             o_wrap,
    output logic [1:0]       o_state
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned CW = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StStep  = 2'b11
    } state_e;

    // Bit 0 is the run button, bit 1 the step button.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    db_level;
    logic [1:0]    press;
    logic [CW-1:0] db_cnt [2];

    assign btn_raw = {i_step_n, i_run_n};

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            sync1     <= '1;
            sync2     <= '1;
            db_level  <= '1;
            press     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            press <= '0;
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] == db_level[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == CW'(DB_CYCLES - 1)) begin
                    db_cnt[b]   <= '0;
                    db_level[b] <= sync2[b];
                    // Only an accepted 1->0 change is a press.
                    press[b]    <= ~sync2[b];
                end else begin
                    db_cnt[b] <= db_cnt[b] + CW'(1);
                end
            end
        end
    end

    logic run_ev;
    logic step_ev;

    assign run_ev  = press[0];
    assign step_ev = press[1];

    state_e            state;
    logic [WIDTH-1:0]  count;
    logic              tick;
    logic              wrap;
    logic [PW-1:0]     pre;
    logic [31:0]       lim_m1;
    logic              pre_hit;
    logic [WIDTH-1:0]  count_adv;
    logic              wrap_adv;

    // A '>=' compare lets a speed change to a shorter period fire at once.
    assign lim_m1    = (32'(TICK_DIV) >> i_speed) - 32'd1;
    assign pre_hit   = 32'(pre) >= lim_m1;
    assign count_adv = i_dir ? count + WIDTH'(1) : count - WIDTH'(1);
    assign wrap_adv  = i_dir ? (count == '1) : (count == '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= StIdle;
            count <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
            pre   <= '0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            unique case (state)
                StIdle, StPause: begin
                    pre <= '0;
                    if (run_ev) begin
                        state <= StRun;
                    end else if (step_ev) begin
                        state <= StStep;
                    end
                end
                StRun: begin
                    if (run_ev) begin
                        state <= StPause;
                        pre   <= '0;
                    end else if (pre_hit) begin
                        pre   <= '0;
                        count <= count_adv;
                        tick  <= 1'b1;
                        wrap  <= wrap_adv;
                    end else begin
                        pre <= pre + PW'(1);
                    end
                end
                StStep: begin
                    pre   <= '0;
                    count <= count_adv;
                    tick  <= 1'b1;
                    wrap  <= wrap_adv;
                    state <= StPause;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign o_count = count;
    assign o_tick  = tick;
    assign o_wrap  = wrap;
    assign o_state = state;

endmodule
